// File: rtl/us_echo_capture_pkg.sv
// us_echo_capture_pkg: shared register map, FSM states and status layout for the echo capture block.
package us_echo_capture_pkg;
    localparam logic [7:0]  REG_FIFO    = 8'h00;
    localparam logic [7:0]  REG_STATUS  = 8'h01;
    localparam logic [7:0]  REG_TX_TIME = 8'h02;
    localparam logic [7:0]  REG_TOF     = 8'h03;
    localparam logic [7:0]  REG_ARM     = 8'h04;
    localparam logic [7:0]  REG_CLEAR   = 8'h05;
    localparam logic [7:0]  REG_BLANK   = 8'h06;
    localparam logic [7:0]  REG_TIMEOUT = 8'h07;
    localparam logic [31:0] DEADBEEF    = 32'hDEAD_BEEF;
    localparam logic [31:0] BLANK_RST   = 32'd100;
    localparam logic [31:0] TIMEOUT_RST = 32'd500000;
    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_OVERFLOW = 2;
    localparam int STAT_TIMEOUT  = 3;
    localparam int STAT_STATE    = 8;
    localparam int STAT_COUNT    = 16;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BLANK = 2'd1, ST_LISTEN = 2'd2} state_t;
endpackage

// File: rtl/us_echo_capture_if.sv
// us_echo_capture_if: Avalon-MM slave bus bundle for the echo capture register file.
interface us_echo_capture_if;
    logic [15:0] address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    modport slave (input address, write, writedata, read, output readdata, waitrequest);
    modport master (output address, write, writedata, read, input readdata, waitrequest);
endinterface

// File: rtl/us_ts_fifo.sv
// us_ts_fifo: synchronous timestamp FIFO; simultaneous push/pop allowed, a pop frees room for a push when full.
module us_ts_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;
    assign o_empty = r_count == '0;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
    always_ff @(posedge i_clock)
        if (w_push & ~i_clear) r_mem[r_wr] <= i_data;
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + AW'(w_push);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/us_echo_capture.sv
// us_echo_capture: echo qualifier, time-of-flight capture and Avalon-MM register file for one receiver channel.
// Define US_ECHO_CAPTURE_IRQ_EN to build the level interrupt; otherwise o_irq is tied low.
module us_echo_capture
    import us_echo_capture_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int FILTER_CYCLES = 4
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [31:0] i_time_cnt,
    input  logic        i_tx_start,
    input  logic        i_echo_in,
    us_echo_capture_if.slave avalon_slave,
    output logic        o_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t        r_state, w_next;
    logic [31:0]   r_cnt, w_cnt_nxt, r_tx_time, r_tof, r_blank, r_timeout;
    logic [31:0]   r_readdata, w_rdata, w_status, w_head, w_arrival;
    logic [1:0]    r_sync;
    logic [3:0]    r_run;
    logic [CW-1:0] w_count;
    logic [7:0]    w_reg;
    logic          r_arm, r_to_flag, r_overflow, r_rd_done, r_pop_pend;
    logic          w_echo, w_qual, w_push, w_to_set, w_pop, w_clear, w_full, w_empty, w_rd_first;

    assign w_reg      = avalon_slave.address[15:8];
    assign w_rd_first = avalon_slave.read & ~r_rd_done;
    assign w_pop      = avalon_slave.read & r_rd_done & r_pop_pend;
    assign w_clear    = avalon_slave.write & (w_reg == REG_CLEAR) & (|avalon_slave.writedata);
    assign avalon_slave.waitrequest = w_rd_first;
    assign avalon_slave.readdata    = r_readdata;

    // Run length saturates at FILTER_CYCLES so a held-high echo qualifies once until a low sample re-arms it.
    assign w_echo    = r_sync[1];
    assign w_qual    = w_echo & (r_run == 4'(FILTER_CYCLES - 1));
    assign w_arrival = i_time_cnt - 32'(FILTER_CYCLES + 2);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
            r_run  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_echo_in};
            r_run  <= !w_echo ? 4'd0 : (r_run == 4'(FILTER_CYCLES) ? r_run : r_run + 4'd1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt + 32'd1;
        w_push    = 1'b0;
        w_to_set  = 1'b0;
        case (r_state)
            ST_BLANK: if (w_cnt_nxt >= r_blank) begin
                w_next    = ST_LISTEN;
                w_cnt_nxt = '0;
            end
            ST_LISTEN: if (w_qual) begin
                w_push = 1'b1;
                w_next = ST_IDLE;
            end else if (w_cnt_nxt >= r_timeout) begin
                w_to_set = 1'b1;
                w_next   = ST_IDLE;
            end
            default: ;
        endcase
        if (i_tx_start) begin
            w_next    = ST_BLANK;
            w_cnt_nxt = '0;
        end
        if (!r_arm) begin
            w_next   = ST_IDLE;
            w_push   = 1'b0;
            w_to_set = 1'b0;
        end
    end

    // tof uses the tx_time held before this edge, so a coincident restart still measures the old shot.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_tx_time <= '0;
            r_tof     <= '0;
        end else begin
            if (i_tx_start & r_arm) r_tx_time <= i_time_cnt;
            if (w_push) r_tof <= w_arrival - r_tx_time;
        end
    end

    us_ts_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_clear),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    (w_arrival),
        .o_data    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_comb begin
        w_status                    = '0;
        w_status[STAT_EMPTY]        = w_empty;
        w_status[STAT_FULL]         = w_full;
        w_status[STAT_OVERFLOW]     = r_overflow;
        w_status[STAT_TIMEOUT]      = r_to_flag;
        w_status[STAT_STATE +: 2]   = r_state;
        w_status[STAT_COUNT +: 8]   = 8'(w_count);
        w_rdata                     = DEADBEEF;
        case (w_reg)
            REG_FIFO:    w_rdata = w_empty ? DEADBEEF : w_head;
            REG_STATUS:  w_rdata = w_status;
            REG_TX_TIME: w_rdata = r_tx_time;
            REG_TOF:     w_rdata = r_tof;
            REG_ARM:     w_rdata = {31'd0, r_arm};
            REG_BLANK:   w_rdata = r_blank;
            REG_TIMEOUT: w_rdata = r_timeout;
            default: ;
        endcase
    end

    // Read data and the pop decision are captured in the wait cycle and presented in the second cycle.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_arm      <= 1'b0;
            r_blank    <= BLANK_RST;
            r_timeout  <= TIMEOUT_RST;
            r_overflow <= 1'b0;
            r_to_flag  <= 1'b0;
            r_rd_done  <= 1'b0;
            r_pop_pend <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (avalon_slave.write && w_reg == REG_ARM)     r_arm     <= |avalon_slave.writedata;
            if (avalon_slave.write && w_reg == REG_BLANK)   r_blank   <= avalon_slave.writedata;
            if (avalon_slave.write && w_reg == REG_TIMEOUT) r_timeout <= avalon_slave.writedata;
            r_overflow <= ~w_clear & (r_overflow | (w_push & w_full & ~w_pop));
            r_to_flag  <= ~w_clear & (r_to_flag | w_to_set);
            r_rd_done  <= w_rd_first;
            if (w_rd_first) begin
                r_readdata <= w_rdata;
                r_pop_pend <= (w_reg == REG_FIFO) & ~w_empty;
            end
        end
    end

`ifdef US_ECHO_CAPTURE_IRQ_EN
    assign o_irq = (~w_empty | r_to_flag | r_overflow) & r_arm;
`else
    assign o_irq = 1'b0;
`endif
endmodule
